// File: rtl/vga_fb_pkg.sv
// Shared constants, state encoding and address helper for the VGA
// frame-buffer write arbiter.
package vga_fb_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int FB_WORDS = H_RES * V_RES;
    localparam int ADDR_W   = 18;
    localparam int COLOR_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SWAP_WAIT
    } fb_state_t;

    typedef struct packed {
        logic [8:0]         x;
        logic [7:0]         y;
        logic [COLOR_W-1:0] color;
    } pixel_req_t;

    function automatic logic pix_in_range(input logic [8:0] x,
                                          input logic [7:0] y);
        return (x < 9'(H_RES)) && (y < 8'(V_RES));
    endfunction

    // y*320 as (y<<8)+(y<<6); the sum always fits in ADDR_W bits
    function automatic logic [ADDR_W-1:0] fb_addr(input logic       back,
                                                  input logic [8:0] x,
                                                  input logic [7:0] y);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] row;
        base = back ? ADDR_W'(FB_WORDS) : '0;
        row  = (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6);
        return base + row + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/vga_vsync_sync.sv
// Brings the asynchronous active-low vsync into the clk domain and
// emits a one-cycle pulse on its falling edge.
module vga_vsync_sync (
    input  logic clk,
    input  logic rst,
    input  logic vs_async,
    output logic fall_pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic edge_q, edge_d;

    always_comb begin
        s1_d   = vs_async;
        s2_d   = s1_q;
        edge_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            edge_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            edge_q <= edge_d;
        end
    end

    assign fall_pulse = edge_q & ~s2_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Round-robin arbiter from two pixel requesters onto the pixel-buffer
// write port, with vsync-aligned front/back buffer swapping.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][8:0]         req_x,
    input  logic [1:0][7:0]         req_y,
    input  logic [1:0][COLOR_W-1:0] req_color,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [COLOR_W-1:0]      mem_wdata,
    output logic                    mem_write,
    input  logic                    mem_waitrequest,
    input  logic                    vga_vs,
    input  logic                    swap_req,
    output logic                    swap_busy,
    output logic                    front_sel,
    output logic [7:0]              drop_count
);

    fb_state_t          state_q, state_d;
    logic               last_q, last_d;
    logic               pending_q, pending_d;
    logic               front_q, front_d;
    logic [7:0]         drop_q, drop_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] wdata_q, wdata_d;
    logic [1:0]         ready;
    logic               win;
    logic               vs_fall;
    pixel_req_t         pix;

    vga_vsync_sync u_vs (
        .clk       (clk),
        .rst       (reset),
        .vs_async  (vga_vs),
        .fall_pulse(vs_fall)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pending_d = pending_q | swap_req;
        front_d   = front_q;
        drop_d    = drop_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ready     = 2'b00;
        win       = 1'b0;
        pix       = '0;
        unique case (state_q)
            IDLE: begin
                // a pending swap freezes grants until the buffers flip
                if (pending_q || swap_req) begin
                    state_d = SWAP_WAIT;
                end else if (|req_valid) begin
                    win       = (&req_valid) ? ~last_q : req_valid[1];
                    pix.x     = req_x[win];
                    pix.y     = req_y[win];
                    pix.color = req_color[win];
                    ready[win] = 1'b1;
                    last_d    = win;
                    if (pix_in_range(pix.x, pix.y)) begin
                        addr_d  = fb_addr(~front_q, pix.x, pix.y);
                        wdata_d = pix.color;
                        state_d = WRITE;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            WRITE: begin
                if (!mem_waitrequest) state_d = IDLE;
            end
            SWAP_WAIT: begin
                if (vs_fall) begin
                    front_d   = ~front_q;
                    pending_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            pending_q <= 1'b0;
            front_q   <= 1'b0;
            drop_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            front_q   <= front_d;
            drop_q    <= drop_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign req_ready  = ready & {2{~reset}};
    assign mem_write  = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign swap_busy  = pending_q;
    assign front_sel  = front_q;
    assign drop_count = drop_q;

endmodule
